// File: rtl/data_pkg.sv
// Shared constants and access-size encodings for the data memory.
package data_pkg;

  typedef enum logic [2:0] {
    ModeNone = 3'b000,
    ModeByte = 3'b001,
    ModeHalf = 3'b011,
    ModeWord = 3'b111
  } mode_e;

  localparam logic [31:0] DATA_BASE  = 32'h8000_0000;
  localparam int unsigned DATA_BYTES = 4096;
  localparam int unsigned DATA_AW    = $clog2(DATA_BYTES);
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;

  // Byte count for a size code; unlisted codes behave as no access.
  function automatic logic [2:0] mode_len(logic [2:0] mode);
    case (mode)
      ModeByte: return 3'd1;
      ModeHalf: return 3'd2;
      ModeWord: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_ram.sv
// Byte-array storage: up to four byte writes per cycle from an arbitrary offset,
// combinational aligned-word read of the pre-write contents.
module data_ram
  import data_pkg::*;
(
  input  logic               clk_i,
  input  logic [DATA_AW-1:0] waddr_i,
  input  logic [2:0]         wlen_i,
  input  logic [31:0]        wdata_i,
  input  logic [DATA_AW-3:0] raddr_i,
  output logic [31:0]        rdata_o
);

  logic [7:0] mem_q [DATA_BYTES];

  // Offset addition wraps naturally at the array size.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < wlen_i) begin
        mem_q[waddr_i + DATA_AW'(i)] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = {mem_q[{raddr_i, 2'd3}], mem_q[{raddr_i, 2'd2}],
                    mem_q[{raddr_i, 2'd1}], mem_q[{raddr_i, 2'd0}]};

endmodule

// File: rtl/data_memory.sv
// Windowed byte-addressed data memory with registered, size-extended reads.
// Define DATA_LOAD_SIGNEXT_EN to sign-extend narrow reads for signed LOAD descriptors.
module data_memory
  import data_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  w_mode,
  input  logic [2:0]  r_mode,
  input  logic [31:0] addr_in,
  input  logic [31:0] din,
  input  logic [9:0]  opc_in,
  output logic [31:0] dout
);

  logic        in_window;
  logic        signed_load;
  logic        unused_opc;
  logic [2:0]  wlen;
  logic [31:0] word;
  logic [31:0] rd_data;
  logic [31:0] dout_q;

  assign in_window = (addr_in[31:DATA_AW] == DATA_BASE[31:DATA_AW]);
  assign wlen      = in_window ? mode_len(w_mode) : 3'd0;

  data_ram u_ram (
    .clk_i   (clk),
    .waddr_i (addr_in[DATA_AW-1:0]),
    .wlen_i  (wlen),
    .wdata_i (din),
    .raddr_i (addr_in[DATA_AW-1:2]),
    .rdata_o (word)
  );

`ifdef DATA_LOAD_SIGNEXT_EN
  assign signed_load = (opc_in[6:0] == OPC_LOAD) && !opc_in[9];
  assign unused_opc  = ^opc_in[8:7];
`else
  assign signed_load = 1'b0;
  assign unused_opc  = ^opc_in;
`endif

  always_comb begin
    rd_data = '0;
    case (mode_len(r_mode))
      3'd4:    rd_data = word;
      3'd2:    rd_data = {{16{signed_load & word[15]}}, word[15:0]};
      3'd1:    rd_data = {{24{signed_load & word[7]}}, word[7:0]};
      default: rd_data = '0;
    endcase
    if (!in_window) rd_data = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) dout_q <= '0;
    else     dout_q <= rd_data;
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed steps plus randomized traffic
// against a byte-array reference model.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  w_mode;
  logic [2:0]  r_mode;
  logic [31:0] addr_in;
  logic [31:0] din;
  logic [9:0]  opc_in;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [4096];

  always #5 clk = ~clk;

  data_memory dut (
    .clk     (clk),
    .rst     (rst),
    .w_mode  (w_mode),
    .r_mode  (r_mode),
    .addr_in (addr_in),
    .din     (din),
    .opc_in  (opc_in),
    .dout    (dout)
  );

  function automatic int unsigned size_of(logic [2:0] m);
    case (m)
      3'b001:  return 1;
      3'b011:  return 2;
      3'b111:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit in_win(logic [31:0] a);
    return (a >= 32'h8000_0000) && (a <= 32'h8000_0FFF);
  endfunction

  function automatic logic [31:0] model_read(logic [2:0] m, logic [31:0] a, logic [9:0] opc);
    int unsigned       n;
    int unsigned       base;
    longint unsigned   word;
    longint unsigned   val;
    longint unsigned   lim;
    bit                ext_en;
    bit                is_load;
    n = size_of(m);
    if (n == 0 || !in_win(a)) return 32'h0;
    base = ((a - 32'h8000_0000) / 4) * 4;
    word = 0;
    for (int i = 0; i < 4; i++) word += longint'(ref_mem[base + i]) << (8 * i);
    lim = 64'd1 << (8 * n);
    val = word % lim;
`ifdef DATA_LOAD_SIGNEXT_EN
    ext_en = 1'b1;
`else
    ext_en = 1'b0;
`endif
    is_load = (int'(opc) % 128 == 3) && (int'(opc) / 512 == 0);
    if (ext_en && is_load && n < 4 && val >= lim / 2) val = val + (64'h1_0000_0000 - lim);
    return 32'(val);
  endfunction

  task automatic model_write(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    int unsigned n;
    int unsigned off;
    n = size_of(m);
    if (!in_win(a)) return;
    off = a - 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      if (i < n) ref_mem[(off + i) % 4096] = d[8*i +: 8];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; dout is compared against the model one cycle later.
  task automatic step(input logic r, input logic [2:0] wm, input logic [2:0] rm,
                      input logic [31:0] a, input logic [31:0] d, input logic [9:0] opc,
                      input string tag);
    logic [31:0] exp;
    rst     = r;
    w_mode  = wm;
    r_mode  = rm;
    addr_in = a;
    din     = d;
    opc_in  = opc;
    exp = r ? 32'h0 : model_read(rm, a, opc);
    model_write(wm, a, d);
    @(posedge clk);
    #1;
    check(tag, dout, exp);
  endtask

  initial begin
    logic [9:0]  opc_ld;
    logic [31:0] exp_signed;
    logic [2:0]  modes [5];
    opc_ld = {3'b000, 7'b0000011};
`ifdef DATA_LOAD_SIGNEXT_EN
    exp_signed = 32'hFFFF_FFEF;
`else
    exp_signed = 32'h0000_00EF;
`endif
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; w_mode = '0; r_mode = '0; addr_in = '0; din = '0; opc_in = '0;

    step(1'b1, 3'b000, 3'b111, 32'h8000_0000, 32'h0, 10'h0, "reset_state");
    // Bring memory to a known all-zero state.
    for (int i = 0; i < 1024; i++) begin
      step(1'b0, 3'b111, 3'b000, 32'h8000_0000 + 32'(i * 4), 32'h0, 10'h0, "clear");
    end

    step(1'b0, 3'b111, 3'b000, 32'h8000_0000, 32'h11AB_CDEF, 10'h0, "wr_word");
    step(1'b0, 3'b000, 3'b111, 32'h8000_0000, 32'h0, 10'h0, "rd_word");
    check("rd_word_const", dout, 32'h11AB_CDEF);

    step(1'b0, 3'b001, 3'b000, 32'h8000_0011, 32'hFFFF_FF11, 10'h0, "wr_byte");
    step(1'b0, 3'b011, 3'b000, 32'h8000_0012, 32'hFFFF_2333, 10'h0, "wr_half");
    step(1'b0, 3'b000, 3'b111, 32'h8000_0010, 32'h0, 10'h0, "rd_mixed");
    check("rd_mixed_const", dout, 32'h2333_1100);
    step(1'b0, 3'b000, 3'b111, 32'h8000_0011, 32'h0, 10'h0, "rd_word_unal");
    check("rd_word_unal_const", dout, 32'h2333_1100);
    step(1'b0, 3'b000, 3'b001, 32'h8000_0011, 32'h0, 10'h0, "rd_byte_unal");
    check("rd_byte_unal_const", dout, 32'h0000_0000);
    step(1'b0, 3'b000, 3'b011, 32'h8000_0012, 32'h0, 10'h0, "rd_half_unal");
    check("rd_half_unal_const", dout, 32'h0000_1100);

    step(1'b0, 3'b111, 3'b000, 32'h8000_0008, 32'h11AB_CDEF, 10'h0, "wr_word8");
    step(1'b0, 3'b000, 3'b001, 32'h8000_0008, 32'h0, 10'h0, "rd_byte_zext");
    check("rd_byte_zext_const", dout, 32'h0000_00EF);
    step(1'b0, 3'b000, 3'b001, 32'h8000_0008, 32'h0, opc_ld, "rd_byte_load");
    check("rd_byte_load_const", dout, exp_signed);

    step(1'b1, 3'b000, 3'b111, 32'h8000_0000, 32'h0, 10'h0, "rst_rd");
    check("rst_rd_const", dout, 32'h0);
    step(1'b0, 3'b000, 3'b000, 32'h8000_0000, 32'h0, 10'h0, "rd_none");
    step(1'b0, 3'b000, 3'b111, 32'h8000_0000, 32'h0, 10'h0, "rd_after_rst");
    check("rd_after_rst_const", dout, 32'h11AB_CDEF);

    step(1'b1, 3'b111, 3'b000, 32'h8000_0004, 32'hCAFE_F00D, 10'h0, "wr_in_rst");
    step(1'b0, 3'b000, 3'b111, 32'h8000_0004, 32'h0, 10'h0, "rd_wr_in_rst");
    check("rd_wr_in_rst_const", dout, 32'hCAFE_F00D);

    step(1'b0, 3'b111, 3'b000, 32'h7FFF_FFFC, 32'hDEAD_BEEF, 10'h0, "wr_out_win");
    step(1'b0, 3'b000, 3'b111, 32'h8000_0FFC, 32'h0, 10'h0, "rd_alias");
    check("rd_alias_const", dout, 32'h0);
    step(1'b0, 3'b000, 3'b111, 32'h9000_0000, 32'h0, 10'h0, "rd_out_win");
    check("rd_out_win_const", dout, 32'h0);

    step(1'b0, 3'b111, 3'b000, 32'h8000_0FFE, 32'hA1B2_C3D4, 10'h0, "wr_wrap");
    step(1'b0, 3'b000, 3'b111, 32'h8000_0000, 32'h0, 10'h0, "rd_wrap_low");
    check("rd_wrap_low_const", dout, 32'h11AB_A1B2);

    step(1'b0, 3'b111, 3'b111, 32'h8000_0010, 32'h5555_AAAA, 10'h0, "rbw_old");
    check("rbw_old_const", dout, 32'h2333_1100);
    step(1'b0, 3'b000, 3'b111, 32'h8000_0010, 32'h0, 10'h0, "rbw_new");

    modes[0] = 3'b000; modes[1] = 3'b001; modes[2] = 3'b011; modes[3] = 3'b111;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [2:0]  wm;
      logic [2:0]  rm;
      logic [9:0]  opc;
      int          sel;
      sel = $urandom_range(0, 7);
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = 32'h8000_0FF8 + $urandom_range(0, 7);
      else               a = 32'h8000_0000 + $urandom_range(0, 31);
      modes[4] = 3'($urandom);
      wm = modes[$urandom_range(0, 4)];
      rm = modes[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 1) opc = {3'($urandom), 7'b0000011};
      else                            opc = 10'($urandom);
      step(($urandom_range(0, 15) == 0), wm, rm, a, $urandom, opc, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and rst, and no other reset exists.
REQ-002 clk  input  1  clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset; clears dout only, never memory contents.
REQ-004 w_mode  input  3  write size: 000 none, 001 byte, 011 halfword, 111 word; all other codes are treated as none.
REQ-005 r_mode  input  3  read size: 000 none, 001 byte, 011 halfword, 111 word; all other codes are treated as none.
REQ-006 addr_in  input  32  byte address; the valid window is 0x8000_0000 to 0x8000_0FFF.
REQ-007 din  input  32  write data; byte lanes are taken from din[7:0] upward.
REQ-008 opc_in  input  10  load descriptor {funct3[9:7], opcode[6:0]}; used only for extension.
REQ-009 dout  output  32  registered read data.

Function
REQ-010 Memory SHALL be 4096 bytes, byte-addressed and little-endian, with offset = addr_in[11:0].
REQ-011 Writes SHALL occur on the rising clk edge; N = 1, 2 or 4 bytes, written from the offset upward.
REQ-012 Writes SHALL be byte-granular with no alignment requirement; the offset wraps modulo 4096.
REQ-013 Reads SHALL fetch the word at the aligned offset {addr_in[11:2], 2'b00}; addr_in[1:0] is ignored on reads.
REQ-014 Word reads SHALL return all 32 bits of the fetched word.
REQ-015 Halfword reads SHALL return the fetched word's bits [15:0], extended to 32 bits.
REQ-016 Byte reads SHALL return the fetched word's bits [7:0], extended to 32 bits.
REQ-017 dout SHALL register the read result on the rising edge (latency 1 cycle); dout = 0 when r_mode is none.
REQ-018 If addr_in is outside the window, writes SHALL be ignored and the registered read value SHALL be 0.
REQ-019 A read and a write in the same cycle SHALL return the pre-write contents (read-before-write).

Reset
REQ-020 While rst = 1 at a rising edge, dout SHALL load 0; rst has priority over the read.
REQ-021 Writes SHALL proceed regardless of rst.
REQ-022 Memory contents SHALL survive reset; memory content at power-up is undefined (simulation initialises it to 0).

Configuration
REQ-023 With macro DATA_LOAD_SIGNEXT_EN defined, narrow reads SHALL sign-extend only when opc_in[6:0] = 7'b0000011 and opc_in[9] = 0.
REQ-024 With DATA_LOAD_SIGNEXT_EN defined, all other narrow reads SHALL zero-extend.
REQ-025 Without DATA_LOAD_SIGNEXT_EN, all narrow reads SHALL zero-extend and opc_in SHALL be ignored.

Structure
REQ-026 Package data_pkg SHALL hold the w_mode/r_mode encodings, DATA_BASE = 32'h8000_0000, DATA_BYTES = 4096 and the LOAD opcode constant.
REQ-027 The byte-array storage SHALL be one sub-module, data_ram (byte write ports plus aligned-word read); data_memory holds the decode, extension and dout register.

Verification
REQ-028 Word write 0x11ABCDEF at 0x8000_0000, then word read there -> dout 0x11ABCDEF one cycle later.
REQ-029 Byte write 0x11 at 0x8000_0011 and halfword 0x2333 at 0x8000_0012; word read at 0x8000_0010 -> 0x23331100.
REQ-030 Reads on the same data at addresses with nonzero addr_in[1:0]:
  - word read at 0x8000_0011 -> 0x23331100 (low 24 bits 0x331100);
  - byte read at 0x8000_0011 -> 0x00000000;
  - halfword read at 0x8000_0012 -> 0x00001100.
REQ-031 Byte read at 0x8000_0008 after a word write of 0x11ABCDEF there -> 0x000000EF; same address with opc_in = {3'b000, 7'b0000011} and the macro defined -> 0xFFFFFFEF.
REQ-032 Assert rst for one cycle with r_mode = 111 -> dout 0; then r_mode = 000 -> dout 0; then word read at 0x8000_0000 -> 0x11ABCDEF (contents retained).
REQ-033 Word write at 0x7FFF_FFFC -> no memory change; read at 0x9000_0000 -> dout 0.
